fixed32_to_bcd: RTL

- Downstream of the CORDIC core. Consumes one 32-bit sign-magnitude Q1.30 result (cos/sin) and produces a sign flag, one integer BCD digit and DIGITS fractional BCD digits for the display/readout stage.
- Conversion is iterative: one multiply-by-10 per clock on the fraction, using shift-add (x<<3 + x<<1).
- Valid/ready handshake on both the input and output sides.

---
 rtl/fixed32_to_bcd.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fixed32_to_bcd.sv
// Sign-magnitude Q1.30 to sign + BCD integer digit + DIGITS BCD fraction digits; optional rounding via FIXED32_TO_BCD_ROUND_EN.
// Latency: out_valid rises DIGITS+1 edges after acceptance (DIGITS+3 with rounding); one x10 step per clock.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so the producer must hold in_valid.
module fixed32_to_bcd #(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [3:0]            out_int,
    output logic [4*DIGITS-1:0]   out_frac
);

    localparam int FW = 4 * DIGITS;

`ifdef FIXED32_TO_BCD_ROUND_EN
    // One extra step produces the guard digit used by ROUND.
    localparam int LAST = DIGITS;
    typedef enum logic [1:0] {S_IDLE, S_CONV, S_ROUND, S_DONE} state_t;
`else
    localparam int LAST = DIGITS - 1;
    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;
`endif

    state_t          state_q, state_d;
    logic [29:0]     frac_q, frac_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      int_q, int_d;
    logic [FW-1:0]   bcd_q, bcd_d;
    logic            sign_q, sign_d;
    logic            valid_q, valid_d;
    logic [33:0]     p;

    assign p = ({4'b0, frac_q} << 3) + ({4'b0, frac_q} << 1);

`ifdef FIXED32_TO_BCD_ROUND_EN
    logic [3:0]      guard_q, guard_d;
    logic [FW-1:0]   rnd_frac;
    logic [3:0]      rnd_int;
    logic            carry;

    // Decimal increment of the fraction with carry rippling into the integer digit.
    always_comb begin
        rnd_frac = bcd_q;
        carry    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    rnd_frac[4*i +: 4] = 4'd0;
                end else begin
                    rnd_frac[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
        rnd_int = int_q + {3'b0, carry};
    end
`endif

    always_comb begin
        state_d = state_q;
        frac_d  = frac_q;
        cnt_d   = cnt_q;
        int_d   = int_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        valid_d = valid_q;
`ifdef FIXED32_TO_BCD_ROUND_EN
        guard_d = guard_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    frac_d  = in_data[29:0];
                    int_d   = {3'b0, in_data[30]};
                    sign_d  = in_data[31] & (in_data[30:0] != 31'd0);
                    cnt_d   = 4'd0;
                    bcd_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                frac_d = p[29:0];
                cnt_d  = cnt_q + 4'd1;
`ifdef FIXED32_TO_BCD_ROUND_EN
                if (cnt_q == 4'(LAST)) begin
                    guard_d = p[33:30];
                    state_d = S_ROUND;
                end else begin
                    bcd_d      = bcd_q << 4;
                    bcd_d[3:0] = p[33:30];
                end
`else
                bcd_d      = bcd_q << 4;
                bcd_d[3:0] = p[33:30];
                if (cnt_q == 4'(LAST)) begin
                    state_d = S_DONE;
                end
`endif
            end
`ifdef FIXED32_TO_BCD_ROUND_EN
            S_ROUND: begin
                if (guard_q >= 4'd5) begin
                    bcd_d = rnd_frac;
                    int_d = rnd_int;
                end
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                // valid is registered, so it rises one edge after DONE is entered.
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            frac_q  <= '0;
            cnt_q   <= '0;
            int_q   <= '0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef FIXED32_TO_BCD_ROUND_EN
            guard_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            frac_q  <= frac_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
            bcd_q   <= bcd_d;
            sign_q  <= sign_d;
            valid_q <= valid_d;
`ifdef FIXED32_TO_BCD_ROUND_EN
            guard_q <= guard_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !reset;
    assign out_valid = valid_q;
    assign out_sign  = sign_q;
    assign out_int   = int_q;
    assign out_frac  = bcd_q;

endmodule
